// File: rtl/sdram_line_reader_if.sv
// SDRAM controller main-port bundle as seen by a read-only client.
// master: the line reader (drives sel/addr/rd/wr/bs/burst).
// slave : the SDRAM controller (drives ready/dout).
interface sdram_line_reader_if;
  logic        sd_sel;
  logic [25:1] sd_addr;
  logic        sd_rd;
  logic        sd_wr;
  logic [1:0]  sd_bs;
  logic        sd_burst;
  logic        sd_ready;
  logic [63:0] sd_dout;

  modport master (
    output sd_sel, sd_addr, sd_rd, sd_wr, sd_bs, sd_burst,
    input  sd_ready, sd_dout
  );

  modport slave (
    input  sd_sel, sd_addr, sd_rd, sd_wr, sd_bs, sd_burst,
    output sd_ready, sd_dout
  );
endinterface

// File: rtl/sdram_line_reader.sv
// Read-only SDRAM client with a direct-mapped cache of 64-bit lines.
// Hits are answered one cycle after the request; misses fetch the whole
// line with one four-word burst and answer when the controller raises ready.
// Optional build macro SDRAM_LINE_READER_STATS_EN adds saturating
// hit/miss counters (hit_cnt, miss_cnt) with a synchronous clear (stats_clr).
module sdram_line_reader #(
  parameter int LINES   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        nRESET,
  input  logic        req,
  input  logic [25:1] req_addr,
  input  logic        flush,
  output logic [15:0] rd_data,
  output logic        ack,
  output logic        busy,
`ifdef SDRAM_LINE_READER_STATS_EN
  input  logic        stats_clr,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
`endif
  sdram_line_reader_if.master sd
);

  localparam int IW  = $clog2(LINES);
  localparam int TGW = 23 - IW;
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, ACCEPT, FILL} state_t;

  state_t           state_q, state_d;
  logic [25:1]      addr_q, addr_d;
  logic [15:0]      rd_data_q, rd_data_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             sel_q, sel_d;
  logic             rd_q, rd_d;
  logic [25:1]      sd_addr_q, sd_addr_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             flushed_q, flushed_d;
  logic [LINES-1:0] valid_q, valid_d;

  logic [63:0]      line_q [LINES];
  logic [TGW-1:0]   tag_q  [LINES];

  logic [IW-1:0]    req_idx, cur_idx;
  logic [TGW-1:0]   req_tag, cur_tag;
  logic             req_hit, fill_done;

  assign req_idx = req_addr[IW+2:3];
  assign req_tag = req_addr[25:IW+3];
  assign cur_idx = addr_q[IW+2:3];
  assign cur_tag = addr_q[25:IW+3];

  // A same-cycle flush wins over the lookup, so the request becomes a miss.
  assign req_hit   = !flush && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign fill_done = (state_q == FILL) && sd.sd_ready;

  // Word k of a line sits in the upper end first: offset 0 is [63:48].
  function automatic logic [15:0] pick_word(input logic [63:0] line,
                                            input logic [1:0]  off);
    logic [15:0] w;
    case (off)
      2'd0:    w = line[63:48];
      2'd1:    w = line[47:32];
      2'd2:    w = line[31:16];
      default: w = line[15:0];
    endcase
    return w;
  endfunction

  // Next-state and output decode for the request/fill sequencer.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_data_d = rd_data_q;
    ack_d     = 1'b0;
    busy_d    = busy_q;
    sel_d     = sel_q;
    rd_d      = rd_q;
    sd_addr_d = sd_addr_q;
    tmo_d     = tmo_q;
    flushed_d = flushed_q;
    valid_d   = flush ? '0 : valid_q;

    // A flush seen while a miss is outstanding keeps that line from
    // being marked valid when it lands.
    if (flush && (state_q != IDLE)) flushed_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d = req_addr;
          if (req_hit) begin
            ack_d     = 1'b1;
            rd_data_d = pick_word(line_q[req_idx], req_addr[2:1]);
          end else begin
            busy_d    = 1'b1;
            flushed_d = 1'b0;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        // ready is low during controller init and while it is busy.
        if (sd.sd_ready) begin
          sel_d     = 1'b1;
          rd_d      = 1'b1;
          sd_addr_d = {addr_q[25:3], 2'b00};
          tmo_d     = '0;
          state_d   = ACCEPT;
        end
      end
      ACCEPT: begin
        if (!sd.sd_ready) begin
          sel_d   = 1'b0;
          rd_d    = 1'b0;
          state_d = FILL;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // Not accepted in time: drop rd for a cycle, then re-issue.
          sel_d   = 1'b0;
          rd_d    = 1'b0;
          state_d = ISSUE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      FILL: begin
        if (sd.sd_ready) begin
          ack_d     = 1'b1;
          rd_data_d = pick_word(sd.sd_dout, addr_q[2:1]);
          busy_d    = 1'b0;
          state_d   = IDLE;
          if (!flushed_q && !flush) valid_d[cur_idx] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset aborts any burst immediately.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= IDLE;
      rd_data_q <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      sel_q     <= 1'b0;
      rd_q      <= 1'b0;
      sd_addr_q <= '0;
      tmo_q     <= '0;
      flushed_q <= 1'b0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      sel_q     <= sel_d;
      rd_q      <= rd_d;
      sd_addr_q <= sd_addr_d;
      tmo_q     <= tmo_d;
      flushed_q <= flushed_d;
      valid_q   <= valid_d;
    end
  end

  // Latched request address and cache storage; validity lives in valid_q.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    if (fill_done) begin
      line_q[cur_idx] <= sd.sd_dout;
      tag_q[cur_idx]  <= cur_tag;
    end
  end

  assign rd_data     = rd_data_q;
  assign ack         = ack_q;
  assign busy        = busy_q;
  assign sd.sd_sel   = sel_q;
  assign sd.sd_addr  = sd_addr_q;
  assign sd.sd_rd    = rd_q;
  assign sd.sd_burst = rd_q;
  assign sd.sd_wr    = 1'b0;
  assign sd.sd_bs    = 2'b11;

`ifdef SDRAM_LINE_READER_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        hit_ev;

  assign hit_ev = (state_q == IDLE) && req && req_hit;

  // Counter update; clear beats a same-cycle increment.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (stats_clr) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      if (hit_ev)    hit_cnt_d  = sat_inc(hit_cnt_q);
      if (fill_done) miss_cnt_d = sat_inc(miss_cnt_q);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_sdram_line_reader.sv
// Scoreboard bench for sdram_line_reader: a behavioural cache model predicts
// hit/miss and data per request, a negedge controller model serves bursts,
// and a monitor pops expected data on every ack.
module tb_sdram_line_reader;
  localparam int LINES   = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        nRESET = 1'b0;
  logic        req = 1'b0;
  logic [25:1] req_addr = '0;
  logic        flush = 1'b0;
  logic [15:0] rd_data;
  logic        ack;
  logic        busy;
`ifdef SDRAM_LINE_READER_STATS_EN
  logic        stats_clr = 1'b0;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  sdram_line_reader_if sd_if();

  sdram_line_reader #(.LINES(LINES), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .nRESET   (nRESET),
    .req      (req),
    .req_addr (req_addr),
    .flush    (flush),
    .rd_data  (rd_data),
    .ack      (ack),
    .busy     (busy),
`ifdef SDRAM_LINE_READER_STATS_EN
    .stats_clr(stats_clr),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
`endif
    .sd       (sd_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Backing memory, one random 64-bit value per line address.
  logic [63:0] mem [int];

  function automatic logic [63:0] line_of(input int la);
    if (!mem.exists(la)) mem[la] = {$urandom, $urandom};
    return mem[la];
  endfunction

  function automatic logic [15:0] word_of(input logic [25:1] a);
    logic [63:0] l;
    int          off;
    l   = line_of(int'(a[25:3]));
    off = int'(a[2:1]);
    return 16'(l >> (16 * (3 - off)));
  endfunction

  // Reference cache: line address stored per index, plus valid flag.
  int m_la [LINES];
  bit m_v  [LINES];

  function automatic bit model_lookup(input logic [25:1] a);
    int la, idx;
    bit h;
    la  = int'(a[25:3]);
    idx = la % LINES;
    h   = m_v[idx] && (m_la[idx] == la);
    m_v[idx]  = 1'b1;
    m_la[idx] = la;
    return h;
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < LINES; i++) m_v[i] = 1'b0;
  endfunction

  logic [15:0] exp_q[$];

  // Controller model, acting on the falling edge.
  bit          hold = 1'b1;
  bit          ignore_rd = 1'b0;
  bit          c_busy = 1'b0;
  int          lat = 3;
  int          c_cnt = 0;
  int          bursts = 0;
  logic [25:1] c_addr = '0;

  always @(negedge clk) begin
    if (c_busy) begin
      c_cnt--;
      if (c_cnt <= 0) begin
        c_busy          = 1'b0;
        sd_if.sd_dout   = line_of(int'(c_addr[25:3]));
        sd_if.sd_ready  = 1'b1;
      end
    end else if (hold) begin
      sd_if.sd_ready = 1'b0;
    end else begin
      sd_if.sd_ready = 1'b1;
      if (sd_if.sd_rd && !ignore_rd) begin
        chk("sd_flags", 64'({sd_if.sd_sel, sd_if.sd_burst, sd_if.sd_wr, sd_if.sd_bs}), 64'h1B);
        c_busy         = 1'b1;
        c_cnt          = lat;
        c_addr         = sd_if.sd_addr;
        bursts++;
        sd_if.sd_ready = 1'b0;
      end
    end
  end

  // Monitor: every ack consumes one expected word.
  always @(negedge clk) begin
    if (nRESET && ack) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_ack: got ack with rd_data %0h, expected no ack", rd_data);
      end else begin
        chk("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
      end
      chk("busy_at_ack", 64'(busy), 64'd0);
    end
  end

  task automatic issue(input logic [25:1] a, input bit wf, output bit hit);
    if (wf) begin
      model_flush();
      flush = 1'b1;
    end
    hit = model_lookup(a);
    exp_q.push_back(word_of(a));
    req_addr = a;
    req      = 1'b1;
    @(negedge clk);
    req   = 1'b0;
    flush = 1'b0;
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 1;
    while (!ack && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    if (!ack) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: no ack after %0d cycles, expected one", cyc);
    end
  endtask

  task automatic do_req(input logic [25:1] a, input bit wf);
    bit hit;
    int b0, cyc;
    b0 = bursts;
    issue(a, wf, hit);
    wait_ack(cyc);
    if (hit) chk("hit_latency", 64'(cyc), 64'd1);
    chk(hit ? "hit_no_burst" : "miss_one_burst", 64'(bursts - b0), hit ? 64'd0 : 64'd1);
    if (!hit) chk("burst_addr", 64'(c_addr), 64'({a[25:3], 2'b00}));
    @(negedge clk);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    model_flush();
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          hit, rd_seen;
    int          cyc, b0, hi, lo, w;
    logic [25:1] a;

    model_flush();
    mem[4] = 64'h1111_2222_3333_4444;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ack",      64'(ack),            64'd0);
    chk("rst_busy",     64'(busy),           64'd0);
    chk("rst_rd_data",  64'(rd_data),        64'd0);
    chk("rst_sd_sel",   64'(sd_if.sd_sel),   64'd0);
    chk("rst_sd_rd",    64'(sd_if.sd_rd),    64'd0);
    chk("rst_sd_addr",  64'(sd_if.sd_addr),  64'd0);
    chk("rst_sd_burst", 64'(sd_if.sd_burst), 64'd0);
    nRESET = 1'b1;

    // Controller not ready: request must wait, then one burst.
    repeat (100) @(negedge clk);
    b0 = bursts;
    issue(25'h000010, 1'b0, hit);
    rd_seen = 1'b0;
    repeat (100) begin
      rd_seen |= sd_if.sd_rd;
      @(negedge clk);
    end
    chk("rd_while_not_ready", 64'(rd_seen), 64'd0);
    hold = 1'b0;
    wait_ack(cyc);
    chk("first_burst_count", 64'(bursts - b0), 64'd1);
    chk("first_burst_addr", 64'(c_addr), 64'h10);
    @(negedge clk);

    // Cold miss on known line data, then a hit in the same line.
    do_flush();
    do_req(25'h000012, 1'b0);
    do_req(25'h000010, 1'b0);

    // Same index, different tag.
    do_req(25'h000000, 1'b0);
    do_req(25'h000020, 1'b0);
    do_req(25'h000000, 1'b0);

    // Flush between requests, and flush together with a request.
    do_req(25'h000008, 1'b0);
    do_flush();
    do_req(25'h000008, 1'b0);
    do_req(25'h000008, 1'b1);

    // Controller ignores the first try: rd held TIMEOUT cycles, dropped one.
    ignore_rd = 1'b1;
    b0 = bursts;
    issue(25'h000100, 1'b0, hit);
    w = 0;
    while (!sd_if.sd_rd && w < 100) begin
      @(negedge clk);
      w++;
    end
    hi = 0;
    while (sd_if.sd_rd && hi < 200) begin
      @(negedge clk);
      hi++;
    end
    ignore_rd = 1'b0;
    lo = 0;
    while (!sd_if.sd_rd && lo < 50) begin
      @(negedge clk);
      lo++;
    end
    chk("timeout_rd_high", 64'(hi), 64'(TIMEOUT));
    chk("timeout_rd_low", 64'(lo), 64'd1);
    wait_ack(cyc);
    chk("timeout_one_burst", 64'(bursts - b0), 64'd1);
    @(negedge clk);

    // Flush while the fill is outstanding: data returned, line not kept.
    lat = 8;
    issue(25'h000400, 1'b0, hit);
    w = 0;
    while (!c_busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    flush = 1'b1;
    model_flush();
    @(negedge clk);
    flush = 1'b0;
    wait_ack(cyc);
    @(negedge clk);
    do_req(25'h000400, 1'b0);

    // Randomized traffic over a small address range.
    repeat (60) begin
      lat = $urandom_range(1, 6);
      a   = 25'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a[25] = 1'b1;
      if ($urandom_range(0, 7) == 0) do_flush();
      do_req(a, $urandom_range(0, 9) == 0);
    end

    // Reset during the fill: no ack, then a fresh burst.
    lat = 20;
    issue(25'h000200, 1'b0, hit);
    w = 0;
    while (!(c_busy && !sd_if.sd_rd) && w < 100) begin
      @(negedge clk);
      w++;
    end
    nRESET = 1'b0;
    #1;
    chk("midreset_sd_rd", 64'(sd_if.sd_rd), 64'd0);
    chk("midreset_busy",  64'(busy),        64'd0);
    exp_q.delete();
    model_flush();
    @(negedge clk);
    @(negedge clk);
    nRESET = 1'b1;
    repeat (30) @(negedge clk);
    lat = 3;
    do_req(25'h000200, 1'b0);

`ifdef SDRAM_LINE_READER_STATS_EN
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    do_flush();
    do_req(25'h000300, 1'b0);
    do_req(25'h000301, 1'b0);
    do_req(25'h000302, 1'b0);
    do_req(25'h000308, 1'b0);
    do_req(25'h000309, 1'b0);
    chk("hit_cnt",  64'(hit_cnt),  64'd3);
    chk("miss_cnt", 64'(miss_cnt), 64'd2);
`endif

    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
